// File: rtl/i2c_accel_target_if.sv
// I2C bus bundle between the accelerometer bus master and the target model.
//   scl    : bus clock as seen on the pad (driven by the master side)
//   sda_in : resolved SDA level on the pad (wired-AND of all drivers)
//   sda_oe : target pull-down enable, 1 = pull SDA low, 0 = release
// Modports: master drives scl/sda_in and observes sda_oe; slave is the target.
interface i2c_accel_target_if;
  logic scl;
  logic sda_in;
  logic sda_oe;

  modport master (
    output scl,
    output sda_in,
    input  sda_oe
  );

  modport slave (
    input  scl,
    input  sda_in,
    output sda_oe
  );
endinterface

// File: rtl/i2c_accel_target.sv
// I2C target modelling the G-sensor accelerometer: a 64-byte register file served at
// 7-bit address 0x1D, with single/burst reads and writes and pointer auto-increment.
// Register 0 holds the read-only device ID 0xE5.
// Ports:
//   clk, reset_n      : system clock (>= 16x SCL) and synchronous active-low reset
//   bus               : I2C pins (scl, sda_in, sda_oe) via i2c_accel_target_if.slave
//   host_we/addr/wdata: local write port into the register file (index 0 ignored)
//   host_rdata        : register[host_addr], registered
//   wr_strobe/addr/data: one-cycle report of every data byte committed by the bus master
//   busy              : high from START until STOP, NACK-to-idle, address miss or reset
module i2c_accel_target (
  input  logic                 clk,
  input  logic                 reset_n,
  i2c_accel_target_if.slave    bus,
  input  logic                 host_we,
  input  logic [5:0]           host_addr,
  input  logic [7:0]           host_wdata,
  output logic [7:0]           host_rdata,
  output logic                 wr_strobe,
  output logic [5:0]           wr_addr,
  output logic [7:0]           wr_data,
  output logic                 busy
);

  localparam logic [6:0] DevAddr = 7'h1D;
  localparam logic [7:0] DevId   = 8'hE5;

  typedef enum logic [3:0] {
    StIdle, StAddr, StAckA, StReg, StAckR, StWdata, StAckW, StRdata, StRack
  } state_e;

  state_e     state_q;
  logic [3:0] cnt_q;
  logic [6:0] shift_q;     // low 7 bits of the byte in flight (rx) or remaining tx bits
  logic [5:0] ptr_q;
  logic       rw_q;
  logic       ack_on_q;    // ACK slot: 0 = waiting for first SCL fall, 1 = driving
  logic       mack_q;      // master ACKed a read byte; next byte loads on SCL fall
  logic [7:0] regs_q [64];
  logic       sda_oe_q, busy_q, wr_strobe_q;
  logic [5:0] wr_addr_q;
  logic [7:0] wr_data_q, host_rdata_q;
  logic       scl_s1_q, scl_s2_q, scl_h_q;
  logic       sda_s1_q, sda_s2_q, sda_h_q;

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rx_byte, rd_byte;

  always_comb begin
    scl_rise  = scl_s2_q & ~scl_h_q;
    scl_fall  = ~scl_s2_q & scl_h_q;
    start_det = scl_s2_q & scl_h_q & ~sda_s2_q & sda_h_q;
    stop_det  = scl_s2_q & scl_h_q & sda_s2_q & ~sda_h_q;
    rx_byte   = {shift_q, sda_s2_q};
    rd_byte   = regs_q[ptr_q];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // Synchronizers reset to the idle bus level so reset never fabricates a START.
      scl_s1_q     <= 1'b1;
      scl_s2_q     <= 1'b1;
      scl_h_q      <= 1'b1;
      sda_s1_q     <= 1'b1;
      sda_s2_q     <= 1'b1;
      sda_h_q      <= 1'b1;
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      shift_q      <= 7'd0;
      ptr_q        <= 6'd0;
      rw_q         <= 1'b0;
      ack_on_q     <= 1'b0;
      mack_q       <= 1'b0;
      sda_oe_q     <= 1'b0;
      busy_q       <= 1'b0;
      wr_strobe_q  <= 1'b0;
      wr_addr_q    <= 6'd0;
      wr_data_q    <= 8'd0;
      host_rdata_q <= 8'd0;
      for (int i = 0; i < 64; i++) begin
        regs_q[i] <= (i == 0) ? DevId : 8'h00;
      end
    end else begin
      scl_s1_q     <= bus.scl;
      scl_s2_q     <= scl_s1_q;
      scl_h_q      <= scl_s2_q;
      sda_s1_q     <= bus.sda_in;
      sda_s2_q     <= sda_s1_q;
      sda_h_q      <= sda_s2_q;
      wr_strobe_q  <= 1'b0;
      host_rdata_q <= regs_q[host_addr];

      if (start_det) begin
        state_q  <= StAddr;
        cnt_q    <= 4'd0;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b1;
        ack_on_q <= 1'b0;
        mack_q   <= 1'b0;
      end else if (stop_det) begin
        state_q  <= StIdle;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
        ack_on_q <= 1'b0;
        mack_q   <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
          end
          StAddr: begin
            if (scl_rise) begin
              shift_q <= rx_byte[6:0];
              cnt_q   <= cnt_q + 4'd1;
              if (cnt_q == 4'd7) begin
                cnt_q <= 4'd0;
                if (rx_byte[7:1] == DevAddr) begin
                  rw_q    <= rx_byte[0];
                  state_q <= StAckA;
                end else begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
                end
              end
            end
          end
          StReg: begin
            if (scl_rise) begin
              shift_q <= rx_byte[6:0];
              cnt_q   <= cnt_q + 4'd1;
              if (cnt_q == 4'd7) begin
                cnt_q   <= 4'd0;
                ptr_q   <= rx_byte[5:0];
                state_q <= StAckR;
              end
            end
          end
          StWdata: begin
            if (scl_rise) begin
              shift_q <= rx_byte[6:0];
              cnt_q   <= cnt_q + 4'd1;
              if (cnt_q == 4'd7) begin
                cnt_q       <= 4'd0;
                state_q     <= StAckW;
                wr_strobe_q <= 1'b1;
                wr_addr_q   <= ptr_q;
                wr_data_q   <= rx_byte;
                if (ptr_q != 6'd0) begin
                  regs_q[ptr_q] <= rx_byte;
                end
                ptr_q <= ptr_q + 6'd1;
              end
            end
          end
          StAckA, StAckR, StAckW: begin
            // First SCL fall starts the ACK pulse, the next one (after the 9th bit) ends it.
            if (scl_fall) begin
              if (!ack_on_q) begin
                sda_oe_q <= 1'b1;
                ack_on_q <= 1'b1;
              end else begin
                ack_on_q <= 1'b0;
                cnt_q    <= 4'd0;
                if (state_q == StAckA && rw_q) begin
                  shift_q  <= rd_byte[6:0];
                  sda_oe_q <= ~rd_byte[7];
                  ptr_q    <= ptr_q + 6'd1;
                  state_q  <= StRdata;
                end else begin
                  sda_oe_q <= 1'b0;
                  state_q  <= (state_q == StAckA) ? StReg : StWdata;
                end
              end
            end
          end
          StRdata: begin
            if (scl_rise) begin
              cnt_q <= cnt_q + 4'd1;
            end else if (scl_fall) begin
              if (cnt_q == 4'd8) begin
                sda_oe_q <= 1'b0;
                cnt_q    <= 4'd0;
                state_q  <= StRack;
              end else begin
                sda_oe_q <= ~shift_q[6];
                shift_q  <= {shift_q[5:0], 1'b0};
              end
            end
          end
          StRack: begin
            if (scl_rise) begin
              if (sda_s2_q) begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
              end else begin
                mack_q <= 1'b1;
              end
            end else if (scl_fall && mack_q) begin
              mack_q   <= 1'b0;
              shift_q  <= rd_byte[6:0];
              sda_oe_q <= ~rd_byte[7];
              ptr_q    <= ptr_q + 6'd1;
              state_q  <= StRdata;
            end
          end
          default: state_q <= StIdle;
        endcase
      end

      // Placed after the bus commit so a same-index host write takes precedence.
      if (host_we && host_addr != 6'd0) begin
        regs_q[host_addr] <= host_wdata;
      end
    end
  end

  assign bus.sda_oe = sda_oe_q;
  assign busy       = busy_q;
  assign wr_strobe  = wr_strobe_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign host_rdata = host_rdata_q;

endmodule
